// File: rtl/alu_pkg.sv
// Shared ALU opcode, branch-op and commit-stage FSM encodings.
// Imported by the commit stage and by the branch condition evaluator.
package alu_pkg;

  typedef enum logic [5:0] {
    OP_NOP = 6'b000000,
    OP_ADD = 6'b000001,
    OP_SUB = 6'b000010,
    OP_MUL = 6'b000011,
    OP_AND = 6'b000100,
    OP_OR  = 6'b000101,
    OP_XOR = 6'b000110,
    OP_SHL = 6'b000111,
    OP_SHR = 6'b001000,
    OP_CMP = 6'b001001
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_JMP  = 3'd1,
    BR_JE   = 3'd2,
    BR_JNE  = 3'd3,
    BR_JA   = 3'd4,
    BR_JNA  = 3'd5,
    BR_JOF  = 3'd6,
    BR_RSVD = 3'd7
  } br_op_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_e;

  // Only add/sub overflow is architecturally a trap; other ops just flag it.
  function automatic logic is_addsub(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational jump condition from branch op and ALU status flags.
// Zero latency; reserved and none encodings never take.
module branch_cond_eval
  import alu_pkg::*;
(
  input  logic [2:0] br_op,
  input  logic       je,
  input  logic       ja,
  input  logic       of,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (br_op_e'(br_op))
      BR_JMP:  cond = 1'b1;
      BR_JE:   cond = je;
      BR_JNE:  cond = !je;
      BR_JA:   cond = ja;
      BR_JNA:  cond = !ja;
      BR_JOF:  cond = of;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_commit_stage.sv
// ALU back end: registers the result for writeback, latches flags, resolves jumps, raises overflow traps.
// One-cycle latency; input stalls while the output is held or a trap awaits acknowledge.
module alu_commit_stage
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter bit TRAP_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        ctrl_alu,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_of,
  input  logic              alu_je,
  input  logic              alu_ja,
  input  logic [2:0]        br_op,
  input  logic [PC_W-1:0]   br_target,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [2:0]        flags,
  output logic              br_taken,
  output logic [PC_W-1:0]   br_pc,
  output logic              trap_req,
  input  logic              trap_ack,
  output logic [CNT_W-1:0]  of_count
);

  state_e state, state_next;
  logic   acc;
  logic   trap;
  logic   cond;

  branch_cond_eval u_cond (
    .br_op (br_op),
    .je    (alu_je),
    .ja    (alu_ja),
    .of    (alu_of),
    .cond  (cond)
  );

  assign acc  = in_valid & in_ready;
  assign trap = acc & TRAP_EN & alu_of & is_addsub(ctrl_alu);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    trap_req   = 1'b0;
    in_ready   = 1'b0;
    case (state)
      ST_RUN: begin
        in_ready = !wb_valid || wb_ready;
        if (trap) state_next = ST_TRAP;
      end
      ST_TRAP: begin
        trap_req = 1'b1;
        if (trap_ack) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  // A new accept wins over a simultaneous drain, so wb_valid stays high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
    end else if (acc && !trap) begin
      wb_valid <= 1'b1;
      wb_data  <= alu_result;
    end else if (wb_valid && wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flags    <= '0;
      of_count <= '0;
    end else if (acc) begin
      flags <= {alu_of, alu_ja, alu_je};
      if (alu_of && (of_count != {CNT_W{1'b1}}))
        of_count <= of_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      br_taken <= 1'b0;
      br_pc    <= '0;
    end else begin
      br_taken <= acc && cond && !trap;
      if (acc && cond && !trap) br_pc <= br_target;
    end
  end

endmodule

// File: tb/tb_alu_commit_stage.sv
// Directed bench for alu_commit_stage with a writeback data scoreboard.
module tb_alu_commit_stage;
  import alu_pkg::*;

  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int CNT_W  = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [5:0]        ctrl_alu = '0;
  logic [DATA_W-1:0] alu_result = '0;
  logic              alu_of = 1'b0;
  logic              alu_je = 1'b0;
  logic              alu_ja = 1'b0;
  logic [2:0]        br_op = '0;
  logic [PC_W-1:0]   br_target = '0;
  logic              wb_valid;
  logic              wb_ready = 1'b1;
  logic [DATA_W-1:0] wb_data;
  logic [2:0]        flags;
  logic              br_taken;
  logic [PC_W-1:0]   br_pc;
  logic              trap_req;
  logic              trap_ack = 1'b0;
  logic [CNT_W-1:0]  of_count;

  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] sb_q[$];
  logic exp_trap = 1'b0;

  alu_commit_stage #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W),
    .TRAP_EN(1'b1),
    .CNT_W  (CNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl_alu  (ctrl_alu),
    .alu_result(alu_result),
    .alu_of    (alu_of),
    .alu_je    (alu_je),
    .alu_ja    (alu_ja),
    .br_op     (br_op),
    .br_target (br_target),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_data   (wb_data),
    .flags     (flags),
    .br_taken  (br_taken),
    .br_pc     (br_pc),
    .trap_req  (trap_req),
    .trap_ack  (trap_ack),
    .of_count  (of_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [DATA_W-1:0] res,
                       input logic of, input logic ja, input logic je,
                       input logic [2:0] bop, input logic [PC_W-1:0] tgt);
    in_valid   = 1'b1;
    ctrl_alu   = op;
    alu_result = res;
    alu_of     = of;
    alu_ja     = ja;
    alu_je     = je;
    br_op      = bop;
    br_target  = tgt;
  endtask

  // Inputs change only just after a rising edge, so the falling edge sees what the next edge will.
  always @(negedge clock) begin
    if (!reset) begin
      if (wb_valid && wb_ready) begin
        if (sb_q.size() == 0) chk("wb_unexpected", 64'(wb_data), 64'hDEAD_0000);
        else                  chk("wb_data_sb", 64'(wb_data), 64'(sb_q.pop_front()));
      end
      if (in_valid && in_ready && !exp_trap) sb_q.push_back(alu_result);
    end
  end

  initial begin
    #2;
    chk("rst_wb_valid", 64'(wb_valid), 0);
    chk("rst_wb_data",  64'(wb_data),  0);
    chk("rst_flags",    64'(flags),    0);
    chk("rst_br_taken", 64'(br_taken), 0);
    chk("rst_br_pc",    64'(br_pc),    0);
    chk("rst_trap_req", 64'(trap_req), 0);
    chk("rst_of_count", 64'(of_count), 0);
    #10;
    reset = 1'b0;
    tick();

    // 1: simple add
    drive(OP_ADD, 32'h5, 0, 0, 0, BR_NONE, '0);
    tick();
    in_valid = 1'b0;
    chk("t1_wb_valid", 64'(wb_valid), 1);
    chk("t1_wb_data",  64'(wb_data),  32'h5);
    chk("t1_flags",    64'(flags),    3'b000);
    chk("t1_br_taken", 64'(br_taken), 0);
    tick();

    // 2: stall then back-to-back replacement
    wb_ready = 1'b0;
    drive(OP_ADD, 32'hAAAA_0000, 0, 0, 0, BR_NONE, '0);
    tick();
    alu_result = 32'h0000_0BAD;
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_valid", 64'(wb_valid), 1);
      chk("t2_hold_data",  64'(wb_data),  32'hAAAA_0000);
      chk("t2_in_ready",   64'(in_ready), 0);
      tick();
    end
    wb_ready   = 1'b1;
    alu_result = 32'h1;
    tick();
    in_valid = 1'b0;
    chk("t2_b2b_valid", 64'(wb_valid), 1);
    chk("t2_b2b_data",  64'(wb_data),  32'h1);
    tick();
    chk("t2_drained", 64'(wb_valid), 0);

    // 3: je taken, then jne not taken
    drive(OP_CMP, 32'h22, 0, 0, 1, BR_JE, 32'h100);
    tick();
    in_valid = 1'b0;
    chk("t3_taken", 64'(br_taken), 1);
    chk("t3_pc",    64'(br_pc),    32'h100);
    tick();
    chk("t3_pulse_end", 64'(br_taken), 0);
    drive(OP_CMP, 32'h33, 0, 0, 1, BR_JNE, 32'h200);
    tick();
    chk("t3_jne_not_taken", 64'(br_taken), 0);
    chk("t3_pc_hold",       64'(br_pc),    32'h100);

    // 4: add overflow traps while the previous result drains
    drive(OP_ADD, 32'hDEAD, 1, 0, 0, BR_JMP, 32'h300);
    exp_trap = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_trap = 1'b0;
    chk("t4_trap_req", 64'(trap_req), 1);
    chk("t4_in_ready", 64'(in_ready), 0);
    chk("t4_wb_valid", 64'(wb_valid), 0);
    chk("t4_flags",    64'(flags),    3'b100);
    chk("t4_of_count", 64'(of_count), 1);
    chk("t4_no_branch", 64'(br_taken), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_trap_hold", 64'(trap_req), 1);
      chk("t4_wb_idle",   64'(wb_valid), 0);
    end
    trap_ack = 1'b1;
    tick();
    trap_ack = 1'b0;
    chk("t4_trap_clear", 64'(trap_req), 0);
    chk("t4_ready_back", 64'(in_ready), 1);
    chk("t4_br_pc_hold", 64'(br_pc),    32'h100);

    // 5: mul overflow only records
    drive(OP_MUL, 32'h77, 1, 0, 0, BR_NONE, '0);
    tick();
    in_valid = 1'b0;
    chk("t5_trap_req", 64'(trap_req), 0);
    chk("t5_wb_valid", 64'(wb_valid), 1);
    chk("t5_wb_data",  64'(wb_data),  32'h77);
    chk("t5_flags",    64'(flags),    3'b100);
    chk("t5_of_count", 64'(of_count), 2);

    // 6: counter saturation, jof branch on non-trapping overflow
    drive(OP_MUL, 32'h88, 1, 0, 0, BR_JOF, 32'h400);
    tick();
    chk("t6_of_count_3", 64'(of_count), 3);
    chk("t6_jof_taken",  64'(br_taken), 1);
    chk("t6_jof_pc",     64'(br_pc),    32'h400);
    drive(OP_MUL, 32'h99, 1, 1, 0, BR_NONE, '0);
    tick();
    in_valid = 1'b0;
    chk("t6_of_sat", 64'(of_count), 3);
    chk("t6_flags",  64'(flags),    3'b110);
    tick();

    // 6: async reset while in TRAP
    drive(OP_SUB, 32'h1234, 1, 0, 0, BR_NONE, '0);
    exp_trap = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_trap = 1'b0;
    chk("t6_trap_req", 64'(trap_req), 1);
    #2;
    reset = 1'b1;
    #1;
    sb_q.delete();
    chk("t6_rst_trap_req", 64'(trap_req), 0);
    chk("t6_rst_of_count", 64'(of_count), 0);
    chk("t6_rst_br_pc",    64'(br_pc),    0);
    chk("t6_rst_flags",    64'(flags),    0);
    #3;
    reset = 1'b0;
    tick();

    // async reset while a result is stalled
    wb_ready = 1'b0;
    drive(OP_ADD, 32'h5555, 0, 0, 0, BR_NONE, '0);
    tick();
    in_valid = 1'b0;
    chk("stall_valid", 64'(wb_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    sb_q.delete();
    chk("stall_rst_valid", 64'(wb_valid), 0);
    chk("stall_rst_data",  64'(wb_data),  0);
    #3;
    reset    = 1'b0;
    wb_ready = 1'b1;
    tick();
    tick();
    chk("sb_empty", 64'(sb_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_commit_stage.md
Name: alu_commit_stage

Overview:
- Execute-stage back end, directly downstream of the ALU.
- Registers the ALU result, latches the je/ja/of status flags, resolves conditional jumps and raises an overflow trap.
- Hands the result to writeback over a valid/ready handshake.
- Sits between the combinational ALU and the register-file writeback port.

Parameters:
- DATA_W, 32, ALU result width.
- PC_W, 32, branch target / program counter width.
- TRAP_EN, 1, 1 = signed overflow on add/sub traps; 0 = overflow only recorded in flags.
- CNT_W, 16, width of the saturating overflow event counter.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  ALU output is a valid operation this cycle.
- in_ready  out  1  stage can accept an operation this cycle.
- ctrl_alu  in  6  ALU opcode of the operation (000001 add, 000010 sub).
- alu_result  in  DATA_W  ALU result.
- alu_of  in  1  ALU overflow flag.
- alu_je  in  1  ALU equal flag.
- alu_ja  in  1  ALU signed-above flag.
- br_op  in  3  0 none, 1 jmp, 2 je, 3 jne, 4 ja, 5 jna, 6 jof, 7 reserved (treated as none).
- br_target  in  PC_W  jump destination.
- wb_valid  out  1  wb_data is valid.
- wb_ready  in  1  writeback consumes wb_data.
- wb_data  out  DATA_W  registered result.
- flags  out  3  {of, ja, je} of the last accepted operation.
- br_taken  out  1  one-cycle pulse: jump resolved taken.
- br_pc  out  PC_W  target; valid while br_taken is high.
- trap_req  out  1  overflow trap pending.
- trap_ack  in  1  trap handler acknowledge.
- of_count  out  CNT_W  saturating count of overflow events.

Behaviour:
- Reset (async, immediate): state=RUN; wb_valid=0, wb_data=0, flags=0, br_taken=0, br_pc=0, trap_req=0, of_count=0.
- Accept: acc = in_valid & in_ready. in_ready = (state==RUN) & (!wb_valid | wb_ready), combinational.
- Trap condition: trap = acc & TRAP_EN & alu_of & (ctrl_alu==000001 | ctrl_alu==000010).
- On every acc, including trapping ones:
  - flags <= {alu_of, alu_ja, alu_je}.
  - of_count increments on acc & alu_of; saturates at all-ones.
- Data path, one-cycle latency:
  - acc & !trap: wb_data <= alu_result; wb_valid <= 1 next cycle.
  - wb_valid & wb_ready & !acc: wb_valid <= 0.
  - Back-to-back accept while wb_ready=1 keeps wb_valid=1 with the new data.
  - wb_data and wb_valid hold stable while wb_valid & !wb_ready.
- Branch resolution:
  - cond = jmp:1, je:alu_je, jne:!alu_je, ja:alu_ja, jna:!alu_ja, jof:alu_of, none/reserved:0.
  - br_taken <= acc & cond & !trap; it is a single-cycle pulse in the cycle after acceptance.
  - br_pc <= br_target on any acc with cond=1 and no trap; otherwise it holds.
- FSM states: RUN, TRAP.
  - RUN -> TRAP on trap. The trapping result is discarded: no wb_valid, no br_taken.
  - A pending wb_valid from the previous operation still drains normally while in TRAP.
  - In TRAP: trap_req=1, in_ready=0.
  - TRAP -> RUN on trap_ack. trap_req drops in the same edge; in_ready may rise in the next cycle.
  - trap_ack in RUN is ignored.
- Reset mid-trap or mid-stall: all state cleared; the pending result is lost.
- Simultaneous wb_ready drain and new acc: the new data wins and wb_valid stays 1.

Decomposition:
- Shared package alu_pkg holds:
  - ALU opcode constants: OP_ADD=6'b000001, OP_SUB=6'b000010, plus the full opcode list.
  - br_op encodings BR_NONE..BR_JOF.
  - FSM state encoding ST_RUN, ST_TRAP.
- One natural sub-module: branch_cond_eval, combinational (br_op, je, ja, of) -> cond. Reused by the later branch predictor check.

Test Plan:
1. Reset released; in_valid=1, ctrl=000001, result=0x00000005, flags 0, wb_ready=1 -> next cycle wb_valid=1, wb_data=0x5, flags=000, br_taken=0.
2. Accept result=0xAAAA0000 with wb_ready=0 for 3 cycles -> wb_data holds 0xAAAA0000, in_ready=0. Then wb_ready=1 with in_valid=1, result=0x1 -> next cycle wb_data=0x1, wb_valid stays 1.
3. br_op=2 (je), alu_je=1, br_target=0x100 -> br_taken pulse for exactly 1 cycle, br_pc=0x100. Repeat with br_op=3 -> br_taken=0, br_pc holds 0x100.
4. ctrl=000001, alu_of=1, TRAP_EN=1 -> trap_req=1, in_ready=0, no wb_valid, flags=100, of_count=1. trap_ack after 4 cycles -> trap_req=0, in_ready=1 in the following cycle.
5. ctrl=000011 (mul) with alu_of=1 -> no trap, wb_valid=1, flags[2]=1, of_count increments.
6. Assert reset asynchronously (between clock edges) during TRAP with wb_valid=1 -> all outputs 0 immediately. With CNT_W=2, four overflow accepts -> of_count saturates at 3.
